// File: rtl/atomik_delta_accumulator_mc_if.sv
// Command/response bus of the multi-channel XOR delta accumulator.
// The master issues commands; the slave (accumulator) returns responses and live zero flags.
interface atomik_delta_accumulator_mc_if #(
   parameter int DATA_WIDTH   = 64,
   parameter int NUM_CHANNELS = 4
);
   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_op;
   logic [CH_W-1:0]         cmd_ch;
   logic [DATA_WIDTH-1:0]   cmd_data;
   logic                    rsp_valid;
   logic [CH_W-1:0]         rsp_ch;
   logic [DATA_WIDTH-1:0]   rsp_data;
   logic                    rsp_zero;
   logic                    rsp_err;
   logic [NUM_CHANNELS-1:0] acc_zero;

   modport master (
      output cmd_valid, cmd_op, cmd_ch, cmd_data,
      input  cmd_ready, rsp_valid, rsp_ch, rsp_data, rsp_zero, rsp_err, acc_zero
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ch, cmd_data,
      output cmd_ready, rsp_valid, rsp_ch, rsp_data, rsp_zero, rsp_err, acc_zero
   );
endinterface

// File: rtl/atomik_delta_accumulator_mc.sv
// Multi-channel XOR delta accumulator with a per-channel delta history ring,
// allowing rollback of up to HISTORY_DEPTH deltas at one pop per cycle.
module atomik_delta_accumulator_mc #(
   parameter int DATA_WIDTH    = 64,
   parameter int NUM_CHANNELS  = 4,
   parameter int HISTORY_DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   atomik_delta_accumulator_mc_if.slave io_cmd
);
   localparam int CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int CNT_W     = $clog2(HISTORY_DEPTH + 1);
   localparam int PTR_W     = (HISTORY_DEPTH > 1) ? $clog2(HISTORY_DEPTH) : 1;
   localparam int MEM_DEPTH = NUM_CHANNELS * HISTORY_DEPTH;
   localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [1:0] OP_LOAD     = 2'd0;
   localparam logic [1:0] OP_ACCUM    = 2'd1;
   localparam logic [1:0] OP_READ     = 2'd2;
   localparam logic [1:0] OP_ROLLBACK = 2'd3;

   typedef enum logic {S_IDLE, S_ROLLBACK} state_t;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == HISTORY_DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_W'(HISTORY_DEPTH - 1) : p - PTR_W'(1);
   endfunction

   state_t                  r_state;
   logic                    r_cmd_ready;
   logic [CH_W-1:0]         r_rb_ch;
   logic [CNT_W-1:0]        r_rb_left;
   logic                    r_rb_err;
   logic                    r_rsp_valid;
   logic [CH_W-1:0]         r_rsp_ch;
   logic [DATA_WIDTH-1:0]   r_rsp_data;
   logic                    r_rsp_zero;
   logic                    r_rsp_err;
   logic [DATA_WIDTH-1:0]   r_hist [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]   r_pop_data;

   logic [DATA_WIDTH-1:0]   w_init [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   w_acc  [NUM_CHANNELS];
   logic [CNT_W-1:0]        w_cnt  [NUM_CHANNELS];
   logic [PTR_W-1:0]        w_ptr  [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_acc_zero;

   logic                    w_ready;
   logic                    w_accept;
   logic                    w_ch_ok;
   logic [CH_W-1:0]         w_ch_idx;
   logic [CH_W-1:0]         w_sel_ch;
   logic [DATA_WIDTH-1:0]   w_sel_init;
   logic [DATA_WIDTH-1:0]   w_sel_acc;
   logic [CNT_W-1:0]        w_sel_cnt;
   logic [PTR_W-1:0]        w_sel_ptr;
   logic [CNT_W-1:0]        w_n;
   logic [PTR_W-1:0]        w_rd_idx;
   logic [AW-1:0]           w_rd_addr;
   logic [AW-1:0]           w_wr_addr;
   logic                    w_mem_we;
   logic [DATA_WIDTH-1:0]   w_acc_after_accum;
   logic [DATA_WIDTH-1:0]   w_acc_after_pop;

   assign w_ready  = r_cmd_ready & ~rst;
   assign w_accept = io_cmd.cmd_valid & w_ready;
   assign w_ch_ok  = (int'(io_cmd.cmd_ch) < NUM_CHANNELS);
   assign w_ch_idx = w_ch_ok ? io_cmd.cmd_ch : '0;
   assign w_sel_ch = (r_state == S_ROLLBACK) ? r_rb_ch : w_ch_idx;

   assign w_sel_init = w_init[w_sel_ch];
   assign w_sel_acc  = w_acc[w_sel_ch];
   assign w_sel_cnt  = w_cnt[w_sel_ch];
   assign w_sel_ptr  = w_ptr[w_sel_ch];
   assign w_n        = io_cmd.cmd_data[CNT_W-1:0];

   // The history read is registered, so the entry for the next pop is fetched one
   // cycle ahead: newest entry on accept, then the one below it while popping.
   assign w_rd_idx  = (r_state == S_ROLLBACK) ? ptr_dec(ptr_dec(w_sel_ptr)) : ptr_dec(w_sel_ptr);
   assign w_rd_addr = AW'(int'(w_sel_ch) * HISTORY_DEPTH + int'(w_rd_idx));
   assign w_wr_addr = AW'(int'(w_ch_idx) * HISTORY_DEPTH + int'(w_sel_ptr));
   assign w_mem_we  = w_accept && w_ch_ok && (io_cmd.cmd_op == OP_ACCUM) && (r_state == S_IDLE);

   assign w_acc_after_accum = w_sel_acc ^ io_cmd.cmd_data;
   assign w_acc_after_pop   = w_sel_acc ^ r_pop_data;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_hist[w_wr_addr] <= io_cmd.cmd_data;
      end
      r_pop_data <= r_hist[w_rd_addr];
   end

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] r_init;
         logic [DATA_WIDTH-1:0] r_acc;
         logic [CNT_W-1:0]      r_cnt;
         logic [PTR_W-1:0]      r_ptr;
         logic                  r_zero;
         logic                  w_hit;
         logic                  w_pop;

         assign w_hit = w_accept && w_ch_ok && (r_state == S_IDLE) && (int'(io_cmd.cmd_ch) == gi);
         assign w_pop = (r_state == S_ROLLBACK) && (int'(r_rb_ch) == gi);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_init <= '0;
               r_acc  <= '0;
               r_cnt  <= '0;
               r_ptr  <= '0;
               r_zero <= 1'b1;
            end else if (w_pop) begin
               r_acc  <= r_acc ^ r_pop_data;
               r_zero <= ((r_acc ^ r_pop_data) == '0);
               r_cnt  <= r_cnt - CNT_W'(1);
               r_ptr  <= ptr_dec(r_ptr);
            end else if (w_hit) begin
               case (io_cmd.cmd_op)
                  OP_LOAD: begin
                     r_init <= io_cmd.cmd_data;
                     r_acc  <= '0;
                     r_cnt  <= '0;
                     r_zero <= 1'b1;
                  end
                  OP_ACCUM: begin
                     r_acc  <= r_acc ^ io_cmd.cmd_data;
                     r_zero <= ((r_acc ^ io_cmd.cmd_data) == '0);
                     r_ptr  <= ptr_inc(r_ptr);
                     // A full ring overwrites its oldest entry; the count saturates.
                     if (int'(r_cnt) != HISTORY_DEPTH) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end

         assign w_init[gi]     = r_init;
         assign w_acc[gi]      = r_acc;
         assign w_cnt[gi]      = r_cnt;
         assign w_ptr[gi]      = r_ptr;
         assign w_acc_zero[gi] = r_zero;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_rb_ch     <= '0;
         r_rb_left   <= '0;
         r_rb_err    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_ch    <= '0;
         r_rsp_data  <= '0;
         r_rsp_zero  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_ch    <= io_cmd.cmd_ch;
                  r_rsp_err   <= 1'b0;
                  if (!w_ch_ok) begin
                     r_rsp_err  <= 1'b1;
                     r_rsp_data <= '0;
                     r_rsp_zero <= 1'b0;
                  end else begin
                     case (io_cmd.cmd_op)
                        OP_LOAD: begin
                           r_rsp_data <= io_cmd.cmd_data;
                           r_rsp_zero <= 1'b1;
                        end
                        OP_ACCUM: begin
                           r_rsp_data <= w_sel_init ^ w_acc_after_accum;
                           r_rsp_zero <= (w_acc_after_accum == '0);
                        end
                        OP_ROLLBACK: begin
                           if ((w_n == '0) || (w_sel_cnt == '0)) begin
                              r_rsp_data <= w_sel_init ^ w_sel_acc;
                              r_rsp_zero <= (w_sel_acc == '0);
                              r_rsp_err  <= (w_n != '0);
                           end else begin
                              r_rsp_valid <= 1'b0;
                              r_state     <= S_ROLLBACK;
                              r_cmd_ready <= 1'b0;
                              r_rb_ch     <= io_cmd.cmd_ch;
                              r_rb_left   <= (w_n > w_sel_cnt) ? w_sel_cnt : w_n;
                              r_rb_err    <= (w_n > w_sel_cnt);
                           end
                        end
                        default: begin
                           r_rsp_data <= w_sel_init ^ w_sel_acc;
                           r_rsp_zero <= (w_sel_acc == '0);
                        end
                     endcase
                  end
               end
            end
            S_ROLLBACK: begin
               r_rb_left <= r_rb_left - CNT_W'(1);
               if (r_rb_left == CNT_W'(1)) begin
                  r_state     <= S_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_ch    <= r_rb_ch;
                  r_rsp_data  <= w_sel_init ^ w_acc_after_pop;
                  r_rsp_zero  <= (w_acc_after_pop == '0);
                  r_rsp_err   <= r_rb_err;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_cmd.cmd_ready = w_ready;
   assign io_cmd.rsp_valid = r_rsp_valid;
   assign io_cmd.rsp_ch    = r_rsp_ch;
   assign io_cmd.rsp_data  = r_rsp_data;
   assign io_cmd.rsp_zero  = r_rsp_zero;
   assign io_cmd.rsp_err   = r_rsp_err;
   assign io_cmd.acc_zero  = w_acc_zero;
endmodule

// File: tb/tb_atomik_delta_accumulator_mc.sv
// Bench for the multi-channel delta accumulator: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of channel state and response timing.
module tb_atomik_delta_accumulator_mc;
   localparam int DW   = 64;
   localparam int NCH  = 5;
   localparam int HD   = 8;
   localparam int CHW  = 3;
   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   atomik_delta_accumulator_mc_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) bus ();

   atomik_delta_accumulator_mc #(
      .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .HISTORY_DEPTH(HD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io_cmd(bus)
   );

   // Model: channel state after the next clock edge, and the outputs expected then.
   logic [DW-1:0] m_init [NCH];
   logic [DW-1:0] m_acc  [NCH];
   logic [DW-1:0] m_hist [NCH][$];
   int            m_rb_left = 0;
   int            m_rb_ch   = 0;
   bit            m_rb_err  = 1'b0;

   bit            e_ready, e_valid, e_zero, e_err;
   logic [CHW-1:0] e_ch;
   logic [DW-1:0] e_data;
   bit            e_lit;
   logic [DW-1:0] l_data;
   bit            l_zero, l_err;
   bit            arm_pend = 1'b0;
   logic [DW-1:0] arm_data;
   bit            arm_zero, arm_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   logic [DW-1:0] pool [4];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   function automatic logic [NCH-1:0] zero_vec();
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++) v[c] = (m_acc[c] == '0);
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_init[c] = '0;
         m_acc[c]  = '0;
         m_hist[c].delete();
      end
      m_rb_left = 0;
   endtask

   task automatic respond(input int ch, input logic [DW-1:0] d, input bit z, input bit er);
      e_valid = 1'b1;
      e_ch    = CHW'(ch);
      e_data  = d;
      e_zero  = z;
      e_err   = er;
      if (arm_pend) begin
         e_lit    = 1'b1;
         l_data   = arm_data;
         l_zero   = arm_zero;
         l_err    = arm_err;
         arm_pend = 1'b0;
      end
   endtask

   task automatic apply(input logic [1:0] op, input int ch, input logic [DW-1:0] d);
      int n, k;
      if (ch >= NCH) begin
         respond(ch, '0, 1'b0, 1'b1);
         return;
      end
      case (op)
         2'd0: begin
            m_init[ch] = d;
            m_acc[ch]  = '0;
            m_hist[ch].delete();
            respond(ch, d, 1'b1, 1'b0);
         end
         2'd1: begin
            m_acc[ch] ^= d;
            m_hist[ch].push_back(d);
            if (m_hist[ch].size() > HD) void'(m_hist[ch].pop_front());
            respond(ch, m_init[ch] ^ m_acc[ch], m_acc[ch] == '0, 1'b0);
         end
         2'd2: respond(ch, m_init[ch] ^ m_acc[ch], m_acc[ch] == '0, 1'b0);
         default: begin
            n = int'(d[CNTW-1:0]);
            k = (n < m_hist[ch].size()) ? n : m_hist[ch].size();
            if (k == 0) begin
               respond(ch, m_init[ch] ^ m_acc[ch], m_acc[ch] == '0, n > 0);
            end else begin
               m_rb_left = k;
               m_rb_ch   = ch;
               m_rb_err  = (n > m_hist[ch].size());
            end
         end
      endcase
   endtask

   // One clock cycle: drive inputs, advance the model across the coming edge.
   task automatic step(input bit r, input bit v, input logic [1:0] op, input logic [CHW-1:0] ch,
                       input logic [DW-1:0] d, output bit accepted);
      rst           = r;
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_ch    = ch;
      bus.cmd_data  = d;
      e_valid  = 1'b0;
      e_lit    = 1'b0;
      accepted = 1'b0;
      if (r) begin
         model_reset();
      end else if (m_rb_left > 0) begin
         m_acc[m_rb_ch] ^= m_hist[m_rb_ch].pop_back();
         m_rb_left--;
         if (m_rb_left == 0)
            respond(m_rb_ch, m_init[m_rb_ch] ^ m_acc[m_rb_ch], m_acc[m_rb_ch] == '0, m_rb_err);
      end else if (v) begin
         accepted = 1'b1;
         apply(op, int'(ch), d);
      end
      e_ready = !r && (m_rb_left == 0);
      chk_en  = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, '0, '0, a);
   endtask

   task automatic drain();
      bit a;
      int t = 0;
      while (m_rb_left > 0 && t < 32) begin
         step(1'b0, 1'b0, 2'd0, '0, '0, a);
         t++;
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [CHW-1:0] ch, input logic [DW-1:0] d);
      bit a;
      int t = 0;
      do begin
         step(1'b0, 1'b1, op, ch, d, a);
         t++;
      end while (!a && t < 64);
      if (!a) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: command op=%0d ch=%0d not accepted within %0d cycles", op, ch, t);
      end
   endtask

   task automatic send_lit(input logic [1:0] op, input logic [CHW-1:0] ch, input logic [DW-1:0] d,
                           input logic [DW-1:0] ld, input bit lz, input bit le);
      drain();
      arm_pend = 1'b1;
      arm_data = ld;
      arm_zero = lz;
      arm_err  = le;
      send(op, ch, d);
      drain();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", DW'(bus.cmd_ready), DW'(e_ready));
         chk("rsp_valid", DW'(bus.rsp_valid), DW'(e_valid));
         if (rst) begin
            chk("reset_rsp_data", bus.rsp_data, '0);
            chk("reset_rsp_err", DW'(bus.rsp_err), '0);
         end
         if (e_valid) begin
            $display("rsp ch=%0d data=%h zero=%0b err=%0b", bus.rsp_ch, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
            chk("rsp_ch", DW'(bus.rsp_ch), DW'(e_ch));
            chk("rsp_data", bus.rsp_data, e_data);
            chk("rsp_zero", DW'(bus.rsp_zero), DW'(e_zero));
            chk("rsp_err", DW'(bus.rsp_err), DW'(e_err));
         end
         if (e_lit) begin
            chk("literal_rsp_data", bus.rsp_data, l_data);
            chk("literal_rsp_zero", DW'(bus.rsp_zero), DW'(l_zero));
            chk("literal_rsp_err", DW'(bus.rsp_err), DW'(l_err));
         end
         chk("acc_zero", DW'(bus.acc_zero), DW'(zero_vec()));
      end
   end

   initial begin
      bit a;
      logic [1:0] op;
      logic [CHW-1:0] ch;
      logic [DW-1:0] d;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_ch    = '0;
      bus.cmd_data  = '0;
      pool[0] = 64'h0000_0000_0000_00FF;
      pool[1] = 64'h1234_5678_90AB_CDEF;
      pool[2] = 64'h8000_0000_0000_0001;
      pool[3] = 64'h0F0F_0F0F_F0F0_F0F0;
      model_reset();
      @(negedge clk);
      #1;
      // Reset held with a command present: reset wins, nothing is accepted.
      step(1'b1, 1'b1, 2'd0, 3'd0, 64'hFFFF, a);
      step(1'b1, 1'b0, 2'd0, 3'd0, '0, a);

      send(2'd0, 3'd0, 64'hAAAA_AAAA_AAAA_AAAA);
      send(2'd1, 3'd0, 64'h5555_5555_5555_5555);
      send_lit(2'd2, 3'd0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

      send(2'd1, 3'd1, 64'h1234_5678_90AB_CDEF);
      send_lit(2'd1, 3'd1, 64'h1234_5678_90AB_CDEF, 64'h0, 1'b1, 1'b0);
      send_lit(2'd2, 3'd0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

      send(2'd0, 3'd2, 64'h0);
      send(2'd1, 3'd2, 64'h1);
      send(2'd1, 3'd2, 64'h2);
      send(2'd1, 3'd2, 64'h4);
      send_lit(2'd3, 3'd2, 64'd2, 64'h1, 1'b0, 1'b0);
      send_lit(2'd3, 3'd2, 64'd5, 64'h0, 1'b1, 1'b1);

      for (int i = 0; i < 10; i++) send(2'd1, 3'd3, 64'd1 << i);
      send_lit(2'd3, 3'd3, 64'd8, 64'h3, 1'b0, 1'b0);
      send_lit(2'd3, 3'd3, 64'd1, 64'h3, 1'b0, 1'b1);

      send_lit(2'd1, 3'd5, 64'hDEAD_BEEF, 64'h0, 1'b0, 1'b1);
      send_lit(2'd2, 3'd7, '0, 64'h0, 1'b0, 1'b1);
      send_lit(2'd2, 3'd3, '0, 64'h3, 1'b0, 1'b0);

      // Streaming: valid held high, one response per cycle.
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 2));
         ch = CHW'($urandom_range(0, 7));
         d  = {$urandom, $urandom};
         step(1'b0, 1'b1, op, ch, d, a);
      end

      // Reset during a rollback after two pops.
      send(2'd0, 3'd4, 64'h0);
      for (int i = 0; i < 4; i++) send(2'd1, 3'd4, {$urandom, $urandom} | 64'h1);
      send(2'd3, 3'd4, 64'd4);
      step(1'b0, 1'b0, 2'd0, '0, '0, a);
      step(1'b0, 1'b0, 2'd0, '0, '0, a);
      step(1'b1, 1'b1, 2'd2, 3'd4, '0, a);
      for (int c = 0; c < NCH; c++) send_lit(2'd2, CHW'(c), '0, 64'h0, 1'b1, 1'b0);

      for (int i = 0; i < 600; i++) begin
         op = 2'($urandom_range(0, 3));
         ch = CHW'($urandom_range(0, 5));
         if (op == 2'd3) d = 64'($urandom_range(0, 10));
         else if ($urandom_range(0, 1) == 1) d = pool[$urandom_range(0, 3)];
         else d = {$urandom, $urandom};
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, op, ch, d, a);
      end
      drain();
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/atomik_delta_accumulator_mc.md
# atomik_delta_accumulator_mc

Multi-channel successor to the single-channel ATOMiK XOR delta accumulator. Holds NUM_CHANNELS independent (initial state, XOR accumulator) pairs. Each channel keeps a HISTORY_DEPTH-deep delta history, so a rollback can undo up to that many deltas, one per cycle. Sits behind the SDK command bus; accepts one command per cycle via valid/ready and returns a single-cycle registered response.

## Interface
- DATA_WIDTH, 64, state/delta width
- NUM_CHANNELS, 4, independent channels (≥1)
- HISTORY_DEPTH, 8, deltas retained per channel for rollback (≥1)
- (local) CH_W = max(1,clog2(NUM_CHANNELS)); CNT_W = clog2(HISTORY_DEPTH+1)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  0=LOAD, 1=ACCUM, 2=READ, 3=ROLLBACK
- cmd_ch  in  CH_W  target channel
- cmd_data  in  DATA_WIDTH  LOAD state / ACCUM delta; ROLLBACK step count in bits [CNT_W-1:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_ch  out  CH_W  channel of response
- rsp_data  out  DATA_WIDTH  channel state (initial ^ acc) after the op
- rsp_zero  out  1  channel accumulator == 0 after the op
- rsp_err  out  1  bad channel, or rollback request exceeded history
- acc_zero  out  NUM_CHANNELS  live per-channel accumulator==0 flags

## Operation
- Reset: all initial/acc regs, history counts and pointers = 0. FSM = IDLE. rsp_* = 0. acc_zero = all ones. cmd_ready = 0 while rst is high.
- FSM states: IDLE, ROLLBACK.
  - IDLE: cmd_ready=1. A command is accepted on cmd_valid && cmd_ready.
  - ROLLBACK: cmd_ready=0.
- LOAD: initial=cmd_data; acc=0; history count=0.
- ACCUM: acc ^= cmd_data; delta pushed into the channel ring buffer.
  - If count==HISTORY_DEPTH, the oldest entry is overwritten and count stays saturated.
  - Otherwise count increments.
- READ: no state change.
- ROLLBACK n (n=cmd_data[CNT_W-1:0]):
  - Effective steps k=min(n,count).
  - k==0: behaves like READ; rsp_err=1 if n>0.
  - k>0: enter ROLLBACK. Each cycle, pop the newest entry (ptr-1, wrapping), acc ^= entry, count--. After k pops, return to IDLE.
  - rsp_err=1 if n>count at accept time.
- cmd_ch ≥ NUM_CHANNELS: no state change; response with rsp_err=1, rsp_data=0, rsp_zero=0.
- Channels are fully independent; an op on one channel never alters another.
- The response has no backpressure. The consumer must take rsp_* on the cycle rsp_valid is high.

## Timing
- LOAD/ACCUM/READ/error/k==0: accepted at edge T; channel state and rsp_* valid in cycle T+1 (rsp_valid high exactly one cycle). Back-to-back commands sustain 1 per cycle.
- ACCUM followed the next cycle by READ on the same channel returns the updated value (no hazard).
- ROLLBACK k>0: accepted at T; pops at edges T+1..T+k; cmd_ready low in cycles T+1..T+k; rsp_valid in cycle T+k+1 together with cmd_ready=1.
- acc_zero is registered and updates in the same cycle as the state change.
- rst asserted mid-rollback: remaining pops abort. Next cycle everything is at reset values; no response is issued.
- Simultaneous rst and cmd_valid: reset wins; the command is dropped.

## Test plan
- Reset, then LOAD ch0 0xAAAA_AAAA_AAAA_AAAA, ACCUM ch0 0x5555_5555_5555_5555, READ ch0 -> rsp_data=0xFFFF_FFFF_FFFF_FFFF, rsp_zero=0, acc_zero[0]=0.
- ACCUM ch1 0x1234567890ABCDEF twice -> acc_zero[1]=1, rsp_zero=1. Ch0 state unchanged (READ ch0 still 0xFFFF…F).
- LOAD ch2 0x0, ACCUM ch2 0x1,0x2,0x4; ROLLBACK ch2 n=2 -> cmd_ready low exactly 2 cycles, rsp_data=0x1, rsp_err=0; then ROLLBACK n=5 -> rsp_data=0x0, rsp_err=1, 1 pop cycle.
- HISTORY_DEPTH=8: 10 ACCUMs of 1<<i (i=0..9) on ch3, ROLLBACK n=8 -> rsp_data=0x3 (oldest two retained in acc), count=0.
- cmd_ch=NUM_CHANNELS (widen CH_W or use NUM_CHANNELS=3) -> rsp_err=1, no channel changed; streaming 16 mixed commands with cmd_valid held high -> 16 responses in consecutive cycles.
- Assert rst during a ROLLBACK n=4 after 2 pops -> no rsp_valid; all READs return 0, acc_zero all ones.
